// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset control sequencer:
// opcodes, state codes, immediate-field selects and ALU operation selects.
package cpu_ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_OP     = 3'd1,
    CLS_OP_IMM = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_BRANCH = 3'd5
  } op_class_t;

  // Immediate field feeding the sign extender; unsupported classes fall back to I.
  function automatic logic [1:0] imm_sel_for(input op_class_t cls);
    case (cls)
      CLS_STORE:  return IMM_S;
      CLS_BRANCH: return IMM_B;
      default:    return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_op_class_dec.sv
// Combinational opcode/funct3 classifier: maps an instruction to its
// execution class and flags anything the sequencer does not support.
module op_class_dec
  import cpu_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output op_class_t  op_class,
  output logic       legal
);

  always_comb begin
    op_class = CLS_NONE;
    legal    = 1'b0;
    case (opcode)
      OPC_OP: begin
        op_class = CLS_OP;
        legal    = 1'b1;
      end
      OPC_OP_IMM: begin
        op_class = CLS_OP_IMM;
        legal    = 1'b1;
      end
      OPC_LOAD: begin
        op_class = CLS_LOAD;
        legal    = 1'b1;
      end
      OPC_STORE: begin
        op_class = CLS_STORE;
        legal    = 1'b1;
      end
      OPC_BRANCH: begin
        // Only BEQ/BNE are implemented; other compares are illegal.
        op_class = CLS_BRANCH;
        legal    = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
      end
      default: begin
        op_class = CLS_NONE;
        legal    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with a memory
// wait timeout. Outputs are combinational and held at zero during reset.
module mc_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] INSTR,
  input  logic        ZERO,
  input  logic        MEM_READY,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic        IORD,
  output logic        IR_WE,
  output logic        PC_WE,
  output logic        PC_SRC,
  output logic        REG_WE,
  output logic        WB_SEL,
  output logic        ALU_SRC_B,
  output logic [1:0]  ALU_OP,
  output logic [1:0]  IMM_SEL,
  output logic        ILLEGAL,
  output logic        BUS_ERR,
  output logic [2:0]  STATE
);

  localparam bit             TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

  // Handshake: MEM_REQ rises in FETCH/MEM and stays high, with IORD and
  // MEM_WE stable, until the cycle MEM_READY is seen or the timeout fires.

  state_t          state_q, state_nxt;
  logic [TO_W-1:0] cnt_q;
  op_class_t       op_class;
  logic            legal;
  logic            waiting;
  logic            timeout_hit;
  logic            unused_instr_bits;

  assign unused_instr_bits = ^{INSTR[31:15], INSTR[11:7]};

  op_class_dec u_dec (
    .opcode   (INSTR[6:0]),
    .funct3   (INSTR[14:12]),
    .op_class (op_class),
    .legal    (legal)
  );

  assign waiting     = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign timeout_hit = TO_EN && waiting && !MEM_READY && (cnt_q == TO_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_nxt;
    end
  end

  // A timeout in FETCH stays in FETCH, so it must clear the counter explicitly.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if ((state_nxt != state_q) || timeout_hit) begin
      cnt_q <= '0;
    end else if (waiting && !MEM_READY && (cnt_q != '1)) begin
      cnt_q <= cnt_q + TO_W'(1);
    end
  end

  always_comb begin
    state_nxt = state_q;
    MEM_REQ   = 1'b0;
    MEM_WE    = 1'b0;
    IORD      = 1'b0;
    IR_WE     = 1'b0;
    PC_WE     = 1'b0;
    PC_SRC    = 1'b0;
    REG_WE    = 1'b0;
    WB_SEL    = 1'b0;
    ALU_SRC_B = 1'b0;
    ALU_OP    = ALU_ADD;
    IMM_SEL   = IMM_I;
    ILLEGAL   = 1'b0;
    BUS_ERR   = 1'b0;

    case (state_q)
      ST_FETCH: begin
        MEM_REQ = 1'b1;
        if (MEM_READY) begin
          IR_WE     = 1'b1;
          PC_WE     = 1'b1;
          state_nxt = ST_DECODE;
        end else if (timeout_hit) begin
          BUS_ERR   = 1'b1;
          state_nxt = ST_FETCH;
        end
      end

      ST_DECODE: begin
        IMM_SEL = imm_sel_for(op_class);
        if (!legal) begin
          ILLEGAL   = 1'b1;
          state_nxt = ST_FETCH;
        end else begin
          state_nxt = ST_EXEC;
        end
      end

      ST_EXEC: begin
        IMM_SEL   = imm_sel_for(op_class);
        state_nxt = ST_FETCH;
        case (op_class)
          CLS_OP: begin
            ALU_OP    = ALU_FUNCT;
            state_nxt = ST_WB;
          end
          CLS_OP_IMM: begin
            ALU_SRC_B = 1'b1;
            ALU_OP    = ALU_FUNCT;
            state_nxt = ST_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            ALU_SRC_B = 1'b1;
            ALU_OP    = ALU_ADD;
            state_nxt = ST_MEM;
          end
          CLS_BRANCH: begin
            // INSTR[12] distinguishes BNE from BEQ and inverts the condition.
            ALU_OP = ALU_SUB;
            if (ZERO ^ INSTR[12]) begin
              PC_WE  = 1'b1;
              PC_SRC = 1'b1;
            end
          end
          default: state_nxt = ST_FETCH;
        endcase
      end

      ST_MEM: begin
        MEM_REQ = 1'b1;
        IORD    = 1'b1;
        MEM_WE  = (op_class == CLS_STORE);
        if (MEM_READY) begin
          state_nxt = (op_class == CLS_LOAD) ? ST_WB : ST_FETCH;
        end else if (timeout_hit) begin
          BUS_ERR   = 1'b1;
          state_nxt = ST_FETCH;
        end
      end

      ST_WB: begin
        REG_WE    = 1'b1;
        WB_SEL    = (op_class == CLS_LOAD);
        state_nxt = ST_FETCH;
      end

      default: state_nxt = ST_FETCH;
    endcase

    if (!RST_N) begin
      MEM_REQ   = 1'b0;
      MEM_WE    = 1'b0;
      IORD      = 1'b0;
      IR_WE     = 1'b0;
      PC_WE     = 1'b0;
      PC_SRC    = 1'b0;
      REG_WE    = 1'b0;
      WB_SEL    = 1'b0;
      ALU_SRC_B = 1'b0;
      ALU_OP    = 2'b00;
      IMM_SEL   = 2'b00;
      ILLEGAL   = 1'b0;
      BUS_ERR   = 1'b0;
    end
  end

  assign STATE = RST_N ? state_q : 3'd0;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: walks each instruction class cycle by cycle
// and compares the packed output vector against hand-computed values.
module tb_mc_ctrl_fsm;

  logic        CLK;
  logic        RST_N;
  logic [31:0] INSTR;
  logic        ZERO;
  logic        MEM_READY;
  logic        MEM_REQ, MEM_WE, IORD, IR_WE, PC_WE, PC_SRC;
  logic        REG_WE, WB_SEL, ALU_SRC_B, ILLEGAL, BUS_ERR;
  logic [1:0]  ALU_OP, IMM_SEL;
  logic [2:0]  STATE;

  int n_checks = 0;
  int n_pass   = 0;

  mc_ctrl_fsm #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .INSTR     (INSTR),
    .ZERO      (ZERO),
    .MEM_READY (MEM_READY),
    .MEM_REQ   (MEM_REQ),
    .MEM_WE    (MEM_WE),
    .IORD      (IORD),
    .IR_WE     (IR_WE),
    .PC_WE     (PC_WE),
    .PC_SRC    (PC_SRC),
    .REG_WE    (REG_WE),
    .WB_SEL    (WB_SEL),
    .ALU_SRC_B (ALU_SRC_B),
    .ALU_OP    (ALU_OP),
    .IMM_SEL   (IMM_SEL),
    .ILLEGAL   (ILLEGAL),
    .BUS_ERR   (BUS_ERR),
    .STATE     (STATE)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Packed view: [17]REQ [16]MEM_WE [15]IORD [14]IR_WE [13]PC_WE [12]PC_SRC
  // [11]REG_WE [10]WB_SEL [9]SRC_B [8:7]ALU_OP [6:5]IMM_SEL [4]ILL [3]BERR [2:0]STATE
  logic [17:0] obs;
  assign obs = {MEM_REQ, MEM_WE, IORD, IR_WE, PC_WE, PC_SRC, REG_WE, WB_SEL,
                ALU_SRC_B, ALU_OP, IMM_SEL, ILLEGAL, BUS_ERR, STATE};

  localparam logic [17:0] E_REQ    = 18'(1) << 17;
  localparam logic [17:0] E_MWE    = 18'(1) << 16;
  localparam logic [17:0] E_IORD   = 18'(1) << 15;
  localparam logic [17:0] E_IRWE   = 18'(1) << 14;
  localparam logic [17:0] E_PCWE   = 18'(1) << 13;
  localparam logic [17:0] E_PCSRC  = 18'(1) << 12;
  localparam logic [17:0] E_REGWE  = 18'(1) << 11;
  localparam logic [17:0] E_WBSEL  = 18'(1) << 10;
  localparam logic [17:0] E_SRCB   = 18'(1) << 9;
  localparam logic [17:0] E_AOP_FN = 18'(1) << 8;
  localparam logic [17:0] E_AOP_SB = 18'(1) << 7;
  localparam logic [17:0] E_IMM_B  = 18'(1) << 6;
  localparam logic [17:0] E_IMM_S  = 18'(1) << 5;
  localparam logic [17:0] E_ILL    = 18'(1) << 4;
  localparam logic [17:0] E_BERR   = 18'(1) << 3;
  localparam logic [17:0] S_DEC    = 18'd1;
  localparam logic [17:0] S_EXEC   = 18'd2;
  localparam logic [17:0] S_MEM    = 18'd3;
  localparam logic [17:0] S_WB     = 18'd4;
  localparam logic [17:0] F_FETCH  = E_REQ | E_IRWE | E_PCWE;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LW   = 32'h0040A103;
  localparam logic [31:0] I_SW   = 32'h0020A423;
  localparam logic [31:0] I_BEQ  = 32'h00108463;
  localparam logic [31:0] I_BNE  = 32'h00109463;
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Called at posedge+2: drive inputs, sample at posedge+3, advance one cycle.
  task automatic step(input string tag, input logic ready, input logic zero,
                      input logic [17:0] exp);
    MEM_READY = ready;
    ZERO      = zero;
    #1;
    check(tag, 32'(obs), 32'(exp));
    @(posedge CLK);
    #2;
  endtask

  initial begin
    RST_N = 1'b0; INSTR = 32'h0; ZERO = 1'b0; MEM_READY = 1'b1;
    @(posedge CLK);
    #2;
    step("rst_hold", 1'b1, 1'b0, 18'd0);
    RST_N = 1'b1;

    INSTR = I_ADDI;
    step("addi_fetch", 1'b1, 1'b0, F_FETCH);
    step("addi_dec",   1'b1, 1'b0, S_DEC);
    step("addi_exec",  1'b1, 1'b0, E_SRCB | E_AOP_FN | S_EXEC);
    step("addi_wb",    1'b1, 1'b0, E_REGWE | S_WB);

    INSTR = I_LW;
    step("lw_fetch",  1'b1, 1'b0, F_FETCH);
    step("lw_dec",    1'b1, 1'b0, S_DEC);
    step("lw_exec",   1'b1, 1'b0, E_SRCB | S_EXEC);
    step("lw_mem_w1", 1'b0, 1'b0, E_REQ | E_IORD | S_MEM);
    step("lw_mem_w2", 1'b0, 1'b0, E_REQ | E_IORD | S_MEM);
    step("lw_mem_rd", 1'b1, 1'b0, E_REQ | E_IORD | S_MEM);
    step("lw_wb",     1'b1, 1'b0, E_REGWE | E_WBSEL | S_WB);

    INSTR = I_SW;
    step("sw_fetch", 1'b1, 1'b0, F_FETCH);
    step("sw_dec",   1'b1, 1'b0, E_IMM_S | S_DEC);
    step("sw_exec",  1'b1, 1'b0, E_SRCB | E_IMM_S | S_EXEC);
    step("sw_mem",   1'b1, 1'b0, E_REQ | E_IORD | E_MWE | S_MEM);

    INSTR = I_BEQ;
    step("beq1_fetch", 1'b1, 1'b0, F_FETCH);
    step("beq1_dec",   1'b1, 1'b1, E_IMM_B | S_DEC);
    step("beq1_taken", 1'b1, 1'b1, E_AOP_SB | E_IMM_B | E_PCWE | E_PCSRC | S_EXEC);
    step("beq0_fetch", 1'b1, 1'b0, F_FETCH);
    step("beq0_dec",   1'b1, 1'b0, E_IMM_B | S_DEC);
    step("beq0_nt",    1'b1, 1'b0, E_AOP_SB | E_IMM_B | S_EXEC);

    INSTR = I_BNE;
    step("bne1_fetch", 1'b1, 1'b1, F_FETCH);
    step("bne1_dec",   1'b1, 1'b1, E_IMM_B | S_DEC);
    step("bne1_nt",    1'b1, 1'b1, E_AOP_SB | E_IMM_B | S_EXEC);
    step("bne0_fetch", 1'b1, 1'b0, F_FETCH);
    step("bne0_dec",   1'b1, 1'b0, E_IMM_B | S_DEC);
    step("bne0_taken", 1'b1, 1'b0, E_AOP_SB | E_IMM_B | E_PCWE | E_PCSRC | S_EXEC);

    INSTR = I_BAD;
    step("ill_fetch", 1'b1, 1'b0, F_FETCH);
    step("ill_dec",   1'b1, 1'b0, E_ILL | S_DEC);

    // FETCH stall straight after the illegal pulse: timeout on 4th wait cycle.
    step("to_f_w1",  1'b0, 1'b0, E_REQ);
    step("to_f_w2",  1'b0, 1'b0, E_REQ);
    step("to_f_w3",  1'b0, 1'b0, E_REQ);
    step("to_f_err", 1'b0, 1'b0, E_REQ | E_BERR);
    INSTR = I_LW;
    step("to_r_w1",  1'b0, 1'b0, E_REQ);
    step("to_r_w2",  1'b0, 1'b0, E_REQ);
    step("to_r_w3",  1'b0, 1'b0, E_REQ);
    step("to_r_win", 1'b1, 1'b0, F_FETCH);

    step("to_m_dec",  1'b1, 1'b0, S_DEC);
    step("to_m_exec", 1'b1, 1'b0, E_SRCB | S_EXEC);
    step("to_m_w1",   1'b0, 1'b0, E_REQ | E_IORD | S_MEM);
    step("to_m_w2",   1'b0, 1'b0, E_REQ | E_IORD | S_MEM);
    step("to_m_w3",   1'b0, 1'b0, E_REQ | E_IORD | S_MEM);
    step("to_m_err",  1'b0, 1'b0, E_REQ | E_IORD | E_BERR | S_MEM);
    step("to_m_back", 1'b1, 1'b0, F_FETCH);

    step("rs_dec",  1'b1, 1'b0, S_DEC);
    step("rs_exec", 1'b1, 1'b0, E_SRCB | S_EXEC);
    step("rs_mem",  1'b0, 1'b0, E_REQ | E_IORD | S_MEM);
    MEM_READY = 1'b1;
    RST_N     = 1'b0;
    #1;
    check("rst_mid_mem", 32'(obs), 32'd0);
    @(posedge CLK);
    #2;
    step("rst_mid_hold", 1'b1, 1'b0, 18'd0);
    RST_N = 1'b1;
    step("rst_release", 1'b0, 1'b0, E_REQ);
    step("rst_refetch", 1'b1, 1'b0, F_FETCH);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
